unidec_checker: RTL and testbench



---
 rtl/unidec_checker.sv | 151 +++++++++++++++
 tb/tb_unidec_checker.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/unidec_checker.sv
// Sardinas-Patterson unique-decipherability checker with a runtime-loadable code table.
// Optional macro UNIDEC_STEP_LIMIT_EN bounds a RUN to MAX_STEPS cycles (ends trapped).
module unidec_checker #(
    parameter  int CHAR_W    = 3,
    parameter  int MAX_CHARS = 4,
    parameter  int NUM_WORDS = 8,
    parameter  int STEP_W    = 8,
    parameter  int MAX_STEPS = 200,
    localparam int WORD_W    = CHAR_W*MAX_CHARS+1,
    localparam int IDX_W     = $clog2(NUM_WORDS),
    localparam int SEL2_W    = $clog2(MAX_CHARS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_addr,
    input  logic [WORD_W-1:0] load_data,
    input  logic              start,
    input  logic [IDX_W-1:0]  sel1,
    input  logic [SEL2_W-1:0] sel2,
    output logic              busy,
    output logic              found,
    output logic              trapped,
    output logic [STEP_W-1:0] step_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [WORD_W-1:0]   code_tab_q [NUM_WORDS];
    logic [WORD_W-1:0]   word_q;
    logic [WORD_W-1:0]   word_d;
    logic                busy_q;
    logic                found_q;
    logic                trapped_q;
    logic [STEP_W-1:0]   step_cnt_q;

    logic [WORD_W-1:0]   other_s;
    logic                self_hit_s;
    logic                move_s;
    logic                limit_hit_s;

    // Invalid prefixes map to a value with no stop bit, so they never match a legal word.
    function automatic logic [WORD_W-1:0] prefix_f(input logic [WORD_W-1:0] w,
                                                   input logic [SEL2_W-1:0] k);
        int                sh;
        logic [WORD_W-1:0] mask;
        sh   = CHAR_W * int'(k);
        mask = (WORD_W'(1) << sh) - WORD_W'(1);
        if ((k != '0) && (int'(k) < MAX_CHARS) && ((w >> (sh + 1)) != '0)) begin
            prefix_f = (w & mask) | (WORD_W'(1) << sh);
        end else begin
            prefix_f = {1'b0, {(WORD_W-1){1'b1}}};
        end
    endfunction

    function automatic logic [WORD_W-1:0] suffix_f(input logic [WORD_W-1:0] w,
                                                   input logic [SEL2_W-1:0] k);
        suffix_f = w >> (CHAR_W * int'(k));
    endfunction

    // One Sardinas-Patterson step: decide self-match, next dangling suffix, or dead end.
    always_comb begin
        other_s    = code_tab_q[sel1];
        self_hit_s = (step_cnt_q != '0) && (word_q == other_s) && (word_q != '0);
        word_d     = '0;
        move_s     = 1'b0;
        if ((other_s != '0) && (other_s == prefix_f(word_q, sel2))) begin
            word_d = suffix_f(word_q, sel2);
            move_s = 1'b1;
        end else if (prefix_f(other_s, sel2) == word_q) begin
            word_d = suffix_f(other_s, sel2);
            move_s = 1'b1;
        end else begin
            word_d = '0;
            move_s = 1'b0;
        end
`ifdef UNIDEC_STEP_LIMIT_EN
        limit_hit_s = (step_cnt_q == STEP_W'(MAX_STEPS - 1));
`else
        limit_hit_s = 1'b0;
`endif
    end

    // Control FSM, code table and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            busy_q     <= 1'b0;
            found_q    <= 1'b0;
            trapped_q  <= 1'b0;
            step_cnt_q <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                code_tab_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (load_en) begin
                        code_tab_q[load_addr] <= load_data;
                        state_q               <= ST_IDLE;
                    end else if (start) begin
                        word_q     <= code_tab_q[sel1];
                        step_cnt_q <= '0;
                        found_q    <= 1'b0;
                        trapped_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (step_cnt_q != '1) begin
                        step_cnt_q <= step_cnt_q + STEP_W'(1);
                    end
                    if (self_hit_s) begin
                        found_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (!move_s) begin
                        word_q    <= '0;
                        trapped_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_DONE;
                    end else begin
                        word_q <= word_d;
                        if (limit_hit_s) begin
                            trapped_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= ST_DONE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign found    = found_q;
    assign trapped  = trapped_q;
    assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_unidec_checker.sv
// Self-checking bench for unidec_checker: per-cycle vector table with a scoreboard queue,
// plus hand sequences for the step limit / long run and asynchronous reset.
module tb_unidec_checker;

    localparam int CHAR_W    = 3;
    localparam int MAX_CHARS = 4;
    localparam int NUM_WORDS = 8;
    localparam int STEP_W    = 8;
    localparam int MAX_STEPS = 4;
    localparam int WORD_W    = 13;
    localparam int IDX_W     = 3;
    localparam int SEL2_W    = 2;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic              load_en   = 1'b0;
    logic [IDX_W-1:0]  load_addr = '0;
    logic [WORD_W-1:0] load_data = '0;
    logic              start     = 1'b0;
    logic [IDX_W-1:0]  sel1      = '0;
    logic [SEL2_W-1:0] sel2      = '0;
    logic              busy;
    logic              found;
    logic              trapped;
    logic [STEP_W-1:0] step_cnt;

    unidec_checker #(
        .CHAR_W(CHAR_W), .MAX_CHARS(MAX_CHARS), .NUM_WORDS(NUM_WORDS),
        .STEP_W(STEP_W), .MAX_STEPS(MAX_STEPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .sel1(sel1), .sel2(sel2),
        .busy(busy), .found(found), .trapped(trapped), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [WORD_W-1:0] W_A  = 13'h0008;
    localparam logic [WORD_W-1:0] W_AA = 13'h0040;

    typedef struct {
        logic              le;
        logic [IDX_W-1:0]  la;
        logic [WORD_W-1:0] ld;
        logic              st;
        logic [IDX_W-1:0]  s1;
        logic [SEL2_W-1:0] s2;
        logic [10:0]       exp;
    } vec_t;

    vec_t        vecs [18];
    logic [10:0] sb_q [$];
    int          n_pass  = 0;
    int          n_total = 0;

    function automatic logic [10:0] pk(input logic b, input logic f, input logic t,
                                       input logic [7:0] s);
        return {b, f, t, s};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: busy/found/trapped/step got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                     name, act[10], act[9], act[8], act[7:0], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic drive(input string name, input logic le, input logic [IDX_W-1:0] la,
                         input logic [WORD_W-1:0] ld, input logic st,
                         input logic [IDX_W-1:0] s1, input logic [SEL2_W-1:0] s2,
                         input logic [10:0] exp);
        load_en   = le;
        load_addr = la;
        load_data = ld;
        start     = st;
        sel1      = s1;
        sel2      = s2;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        check(name, {busy, found, trapped, step_cnt}, sb_q.pop_front());
    endtask

    initial begin
        // Table load, found path, invalid split, self-compare suppression
        vecs[0]  = '{1'b1, 3'd0, W_A,    1'b0, 3'd0, 2'd0, pk(1'b0, 1'b0, 1'b0, 8'd0)};
        vecs[1]  = '{1'b1, 3'd1, W_AA,   1'b0, 3'd0, 2'd0, pk(1'b0, 1'b0, 1'b0, 8'd0)};
        vecs[2]  = '{1'b0, 3'd0, 13'h0,  1'b1, 3'd1, 2'd0, pk(1'b1, 1'b0, 1'b0, 8'd0)};
        vecs[3]  = '{1'b0, 3'd0, 13'h0,  1'b0, 3'd0, 2'd1, pk(1'b1, 1'b0, 1'b0, 8'd1)};
        vecs[4]  = '{1'b0, 3'd0, 13'h0,  1'b0, 3'd0, 2'd1, pk(1'b0, 1'b1, 1'b0, 8'd2)};
        vecs[5]  = '{1'b0, 3'd0, 13'h0,  1'b0, 3'd0, 2'd0, pk(1'b0, 1'b1, 1'b0, 8'd2)};
        vecs[6]  = '{1'b0, 3'd0, 13'h0,  1'b1, 3'd1, 2'd0, pk(1'b1, 1'b0, 1'b0, 8'd0)};
        vecs[7]  = '{1'b0, 3'd0, 13'h0,  1'b0, 3'd0, 2'd0, pk(1'b0, 1'b0, 1'b1, 8'd1)};
        vecs[8]  = '{1'b0, 3'd0, 13'h0,  1'b1, 3'd0, 2'd0, pk(1'b1, 1'b0, 1'b0, 8'd0)};
        vecs[9]  = '{1'b0, 3'd0, 13'h0,  1'b0, 3'd0, 2'd1, pk(1'b0, 1'b0, 1'b1, 8'd1)};
        // load_en beats start (from DONE, then from IDLE); writes verified by the run after
        vecs[10] = '{1'b1, 3'd2, W_AA,   1'b1, 3'd2, 2'd0, pk(1'b0, 1'b0, 1'b1, 8'd1)};
        vecs[11] = '{1'b1, 3'd3, W_A,    1'b1, 3'd3, 2'd0, pk(1'b0, 1'b0, 1'b1, 8'd1)};
        vecs[12] = '{1'b0, 3'd0, 13'h0,  1'b1, 3'd2, 2'd0, pk(1'b1, 1'b0, 1'b0, 8'd0)};
        vecs[13] = '{1'b0, 3'd0, 13'h0,  1'b0, 3'd3, 2'd1, pk(1'b1, 1'b0, 1'b0, 8'd1)};
        vecs[14] = '{1'b0, 3'd0, 13'h0,  1'b0, 3'd3, 2'd1, pk(1'b0, 1'b1, 1'b0, 8'd2)};
        // load_en while busy must not clear table[0]
        vecs[15] = '{1'b0, 3'd0, 13'h0,  1'b1, 3'd1, 2'd0, pk(1'b1, 1'b0, 1'b0, 8'd0)};
        vecs[16] = '{1'b1, 3'd0, 13'h0,  1'b0, 3'd0, 2'd1, pk(1'b1, 1'b0, 1'b0, 8'd1)};
        vecs[17] = '{1'b0, 3'd0, 13'h0,  1'b0, 3'd0, 2'd1, pk(1'b0, 1'b1, 1'b0, 8'd2)};

        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("reset_state", {busy, found, trapped, step_cnt}, pk(1'b0, 1'b0, 1'b0, 8'd0));

        for (int i = 0; i < 18; i++) begin
            drive($sformatf("vec%0d", i), vecs[i].le, vecs[i].la, vecs[i].ld,
                  vecs[i].st, vecs[i].s1, vecs[i].s2, vecs[i].exp);
        end

        // Non-deciding run: word settles on "a" and sel1=1 ("aa") keeps it there
        drive("long_start", 1'b0, 3'd0, 13'h0, 1'b1, 3'd1, 2'd0, pk(1'b1, 1'b0, 1'b0, 8'd0));
        drive("long_s1",    1'b0, 3'd0, 13'h0, 1'b0, 3'd0, 2'd1, pk(1'b1, 1'b0, 1'b0, 8'd1));
        drive("long_s2",    1'b0, 3'd0, 13'h0, 1'b0, 3'd1, 2'd1, pk(1'b1, 1'b0, 1'b0, 8'd2));
        drive("long_s3",    1'b0, 3'd0, 13'h0, 1'b0, 3'd1, 2'd1, pk(1'b1, 1'b0, 1'b0, 8'd3));
`ifdef UNIDEC_STEP_LIMIT_EN
        drive("limit_trap", 1'b0, 3'd0, 13'h0, 1'b0, 3'd1, 2'd1, pk(1'b0, 1'b0, 1'b1, 8'd4));
        drive("b_start",    1'b0, 3'd0, 13'h0, 1'b1, 3'd1, 2'd0, pk(1'b1, 1'b0, 1'b0, 8'd0));
        drive("b_step",     1'b0, 3'd0, 13'h0, 1'b0, 3'd0, 2'd1, pk(1'b1, 1'b0, 1'b0, 8'd1));
`else
        for (int i = 0; i < 300; i++) begin
            drive($sformatf("hold%0d", i), 1'b0, 3'd0, 13'h0, 1'b0, 3'd1, 2'd1,
                  pk(1'b1, 1'b0, 1'b0, (4 + i > 255) ? 8'd255 : 8'(4 + i)));
        end
`endif

        // Asynchronous reset mid-RUN (word is "a"), then the table must read as cleared
        load_en = 1'b0;
        start   = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("reset_async", {busy, found, trapped, step_cnt}, pk(1'b0, 1'b0, 1'b0, 8'd0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive("clr_start", 1'b0, 3'd0, 13'h0, 1'b1, 3'd1, 2'd0, pk(1'b1, 1'b0, 1'b0, 8'd0));
        drive("clr_step",  1'b0, 3'd0, 13'h0, 1'b0, 3'd0, 2'd1, pk(1'b0, 1'b0, 1'b1, 8'd1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
